// File: rtl/instruction_fetch.sv
// Instruction fetch with a two-pass flow: a label pass records branch targets, then a run pass
// fetches and redirects through the recorded label table.
module instruction_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] program_counter,
  output logic [7:0] instruction,
  output logic       instr_valid,
  output logic       labelPassFlag,
  input  logic       labelFlag,
  input  logic [3:0] labelIndex,
  input  logic [7:0] labelValue,
  input  logic       branchTaken,
  input  logic [3:0] branchIndex,
  input  logic       outputPCResetFlag,
  input  logic       haltFlag,
  output logic       halted,
  output logic       fault
);
  typedef enum logic [1:0] {IDLE, LABEL_PASS, RUN, HALTED} state_t;

  state_t            r_state, w_nxt;
  logic [7:0]        r_pc, r_pcout, r_ins;
  logic              r_vld, r_lpf, r_halted, r_fault;
  logic [15:0][7:0]  r_tab;
  logic [15:0]       r_tab_vld;

  logic w_fetch, w_pc_zero, w_redir, w_tab_we, w_stop, w_fault;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Priority inside RUN: halt beats branch beats increment.
  always_comb begin
    w_nxt     = r_state;
    w_fetch   = 1'b0;
    w_pc_zero = 1'b0;
    w_redir   = 1'b0;
    w_tab_we  = 1'b0;
    w_stop    = 1'b0;
    w_fault   = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_nxt     = LABEL_PASS;
        w_pc_zero = 1'b1;
      end
      LABEL_PASS: begin
        w_tab_we = labelFlag;
        if (outputPCResetFlag) begin
          w_nxt     = RUN;
          w_pc_zero = 1'b1;
        end else begin
          w_fetch = 1'b1;
        end
      end
      RUN: begin
        if (haltFlag) begin
          w_nxt  = HALTED;
          w_stop = 1'b1;
        end else if (branchTaken) begin
          if (r_tab_vld[branchIndex]) begin
            w_redir = 1'b1;
          end else begin
            w_nxt   = HALTED;
            w_stop  = 1'b1;
            w_fault = 1'b1;
          end
        end else begin
          w_fetch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= 8'h00;
      r_pcout   <= 8'h00;
      r_ins     <= 8'h00;
      r_vld     <= 1'b0;
      r_lpf     <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
      r_tab_vld <= '0;
    end else begin
      if (w_tab_we) begin
        r_tab[labelIndex]     <= labelValue;
        r_tab_vld[labelIndex] <= 1'b1;
      end
      if (w_pc_zero)    r_pc <= 8'h00;
      else if (w_redir) r_pc <= r_tab[branchIndex];
      else if (w_fetch) r_pc <= r_pc + 8'h01;
      if (w_fetch) begin
        r_ins   <= imem_data;
        r_pcout <= r_pc;
      end
      // Valid only on plain fetches: flushes, redirects, halts and idle all bubble.
      r_vld <= w_fetch;
      r_lpf <= (w_nxt == LABEL_PASS);
      if (w_stop)  r_halted <= 1'b1;
      if (w_fault) r_fault  <= 1'b1;
    end
  end

  assign imem_addr       = r_pc;
  assign program_counter = r_pcout;
  assign instruction     = r_ins;
  assign instr_valid     = r_vld;
  assign labelPassFlag   = r_lpf;
  assign halted          = r_halted;
  assign fault           = r_fault;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random episodes, checked every cycle
// against a mode-based reference model of the fetch/label/branch rules.
module tb_instruction_fetch;
  logic       clk = 1'b0;
  logic       reset, start, labelFlag, branchTaken, outputPCResetFlag, haltFlag;
  logic [3:0] labelIndex, branchIndex;
  logic [7:0] labelValue, imem_addr, imem_data, program_counter, instruction;
  logic       instr_valid, labelPassFlag, halted, fault;

  logic [7:0] rom [256];
  assign imem_data = rom[imem_addr];

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .program_counter(program_counter), .instruction(instruction), .instr_valid(instr_valid),
    .labelPassFlag(labelPassFlag), .labelFlag(labelFlag), .labelIndex(labelIndex),
    .labelValue(labelValue), .branchTaken(branchTaken), .branchIndex(branchIndex),
    .outputPCResetFlag(outputPCResetFlag), .haltFlag(haltFlag), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: mode names, PC as an integer, labels as a slot->target map.
  localparam int M_IDLE = 0, M_LABEL = 1, M_RUN = 2, M_HALT = 3;
  int         m_mode, m_pc;
  logic [7:0] m_pcout, m_ins;
  bit         m_vld, m_lpf, m_halt, m_fault;
  int         m_labels [int];

  int n_pass = 0, n_total = 0;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fetch_one();
    m_ins   = rom[m_pc];
    m_pcout = 8'(m_pc);
    m_vld   = 1;
    m_pc    = (m_pc + 1) % 256;
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = M_IDLE; m_pc = 0; m_pcout = 0; m_ins = 0;
      m_vld = 0; m_lpf = 0; m_halt = 0; m_fault = 0;
      m_labels.delete();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_vld = 0;
        if (start) begin m_mode = M_LABEL; m_pc = 0; m_lpf = 1; end
      end
      M_LABEL: begin
        if (labelFlag) m_labels[int'(labelIndex)] = int'(labelValue);
        if (outputPCResetFlag) begin
          m_mode = M_RUN; m_pc = 0; m_lpf = 0; m_vld = 0;
        end else fetch_one();
      end
      M_RUN: begin
        if (haltFlag) begin
          m_mode = M_HALT; m_halt = 1; m_vld = 0;
        end else if (branchTaken) begin
          m_vld = 0;
          if (m_labels.exists(int'(branchIndex))) m_pc = m_labels[int'(branchIndex)];
          else begin m_mode = M_HALT; m_halt = 1; m_fault = 1; end
        end else fetch_one();
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("imem_addr", imem_addr, 8'(m_pc));
    chk("program_counter", program_counter, m_pcout);
    chk("instruction", instruction, m_ins);
    chk("instr_valid", {7'b0, instr_valid}, {7'b0, m_vld});
    chk("labelPassFlag", {7'b0, labelPassFlag}, {7'b0, m_lpf});
    chk("halted", {7'b0, halted}, {7'b0, m_halt});
    chk("fault", {7'b0, fault}, {7'b0, m_fault});
  endtask

  task automatic drv(bit st, bit lf, logic [3:0] li, logic [7:0] lv,
                     bit bt, logic [3:0] bi, bit opr, bit hf);
    start = st; labelFlag = lf; labelIndex = li; labelValue = lv;
    branchTaken = bt; branchIndex = bi; outputPCResetFlag = opr; haltFlag = hf;
    tick();
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; nop(); reset = 0;
  endtask

  task automatic rnd(int p_lf, int p_bt, int p_opr, int p_hf);
    drv($urandom_range(0, 99) < 10, $urandom_range(0, 99) < p_lf, 4'($urandom), 8'($urandom),
        $urandom_range(0, 99) < p_bt, 4'($urandom), $urandom_range(0, 99) < p_opr,
        $urandom_range(0, 99) < p_hf);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    reset = 1; start = 0; labelFlag = 0; labelIndex = 0; labelValue = 0;
    branchTaken = 0; branchIndex = 0; outputPCResetFlag = 0; haltFlag = 0;
    tick(); tick();
    reset = 0;
    // Idle holds reset values; non-start inputs have no effect.
    for (int i = 0; i < 3; i++) drv(0, 1, 4'd3, 8'h77, 1, 4'd3, 1, 1);

    // Start, three fetches, label slot 3 = 0x05, switch to run, branch to slot 3.
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    nop(); nop();
    drv(0, 1, 4'd3, 8'h05, 1, 4'd3, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    nop(); nop(); nop();
    drv(1, 0, 0, 0, 1, 4'd3, 0, 0);
    nop(); nop();
    // Branch to never-written slot 9: fault, then frozen under random inputs.
    drv(0, 0, 0, 0, 1, 4'd9, 0, 0);
    for (int i = 0; i < 10; i++) rnd(50, 50, 50, 50);

    // Label write on the same edge as the run switch; overwrite; halt beats branch.
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 4'd7, 8'h10, 0, 0, 0, 0);
    drv(0, 1, 4'd7, 8'h20, 0, 0, 0, 0);
    drv(0, 1, 4'd2, 8'h30, 0, 0, 1, 0);
    nop();
    drv(0, 0, 0, 0, 1, 4'd7, 0, 0);
    nop();
    drv(0, 0, 0, 0, 1, 4'd2, 0, 0);
    nop();
    drv(0, 0, 0, 0, 1, 4'd7, 0, 1);
    nop(); nop();

    // Long run without branches crosses the 0xFF -> 0x00 wrap.
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 262; i++) nop();

    // Reset mid-run at pc 0x40 clears the table: branch to slot 3 then faults.
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 4'd3, 8'h05, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    for (int g = 0; g < 300 && m_pc != 8'h40; g++) nop();
    chk("pc_reached_40", imem_addr, 8'h40);
    do_reset();
    nop();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    nop();
    drv(0, 0, 0, 0, 1, 4'd3, 0, 0);
    nop(); nop();

    // Random episodes.
    for (int e = 0; e < 6; e++) begin
      do_reset();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) rnd(40, 30, 0, 30);
      drv(0, 1, 4'($urandom), 8'($urandom), 0, 0, 1, 0);
      for (int i = 0; i < 150; i++) rnd(30, 15, 30, 1);
      for (int i = 0; i < 5; i++) rnd(50, 50, 50, 50);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port list, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin label pass; sampled in IDLE only
- imem_addr  out  8  instruction ROM address, combinational copy of internal PC
- imem_data  in  8  ROM data, combinationally valid for imem_addr in the same cycle
- program_counter  out  8  PC of the instruction currently presented
- instruction  out  8  registered instruction word to decode
- instr_valid  out  1  instruction/program_counter are meaningful this cycle
- labelPassFlag  out  1  high during label pass
- labelFlag  in  1  decode executed stl this cycle
- labelIndex  in  4  label slot written by stl
- labelValue  in  8  PC recorded by stl
- branchTaken  in  1  resolved blt is taken this cycle
- branchIndex  in  4  label slot targeted by branch
- outputPCResetFlag  in  1  halt seen during label pass; start real run
- haltFlag  in  1  halt seen during run
- halted  out  1  execution stopped
- fault  out  1  branch to an unwritten label slot

Function
REQ-003 The FSM SHALL have states IDLE, LABEL_PASS, RUN and HALTED.
REQ-004 The label table SHALL hold 16 entries of 8 bits, each with a valid bit.
REQ-005 In IDLE with start=1, the FSM SHALL go to LABEL_PASS and set pc=0 and labelPassFlag=1 on the next edge.
REQ-006 Outside IDLE, start SHALL be ignored.
REQ-007 In LABEL_PASS and RUN, on each edge with no redirect, the block SHALL apply:
- instruction <= imem_data
- program_counter <= pc
- instr_valid <= 1
- pc <= pc+1, 8-bit wrap (0xFF -> 0x00)
- Fetch latency is one cycle from address to instruction.
REQ-008 In LABEL_PASS, labelFlag=1 SHALL write labelValue to table[labelIndex] and set its valid bit on that edge.
REQ-009 In LABEL_PASS, a rewrite of an already-valid slot SHALL overwrite it (last writer wins).
REQ-010 In RUN, labelFlag SHALL NOT modify the table.
REQ-011 In LABEL_PASS, outputPCResetFlag=1 SHALL, on that edge:
- set pc=0, state=RUN, labelPassFlag=0
- force instr_valid=0 for one cycle (flush)
- leave the table unchanged
REQ-012 In RUN, branchTaken=1 with table[branchIndex] valid SHALL, on that edge:
- set pc=table[branchIndex]
- force instr_valid=0 for one cycle
REQ-013 In RUN, branchTaken=1 with table[branchIndex] invalid SHALL set fault=1, halted=1 and state=HALTED.
REQ-014 In RUN, haltFlag=1 SHALL set state=HALTED, halted=1 and instr_valid=0.
REQ-015 In HALTED, pc, instruction and program_counter SHALL freeze, and all inputs except reset SHALL be ignored.
REQ-016 Simultaneous events SHALL resolve by priority reset > haltFlag > outputPCResetFlag > branchTaken > increment.
REQ-017 labelFlag on the same edge as outputPCResetFlag SHALL still write the table.
REQ-018 branchTaken and haltFlag SHALL be ignored in LABEL_PASS; outputPCResetFlag SHALL be ignored in RUN.
REQ-019 In IDLE, instr_valid=0 and pc SHALL hold.
REQ-020 The block SHALL NOT stop at PC wrap; it runs until halt.

Reset
REQ-021 On reset=1 at an edge, the block SHALL force:
- state=IDLE, pc=0, program_counter=0x00, instruction=0x00
- instr_valid=0, labelPassFlag=0, halted=0, fault=0
- all 16 valid bits cleared
REQ-022 Reset SHALL take effect mid-operation in any state, with no partial table write on that edge.
REQ-023 After reset deasserts, outputs SHALL hold their reset values until start.

Verification
REQ-024 Start/sequence: reset, start -> labelPassFlag=1; instructions from ROM 0x00,0x01,0x02 appear on consecutive cycles with instr_valid=1 and program_counter 0,1,2.
REQ-025 Label pass: labelFlag at labelIndex=3, labelValue=0x05, then outputPCResetFlag -> one cycle instr_valid=0, then program_counter=0, labelPassFlag=0, state RUN.
REQ-026 Branch: in RUN, branchTaken with branchIndex=3 -> one bubble, then program_counter=0x05.
REQ-027 Unwritten label: branchTaken with branchIndex=9 never written -> fault=1, halted=1, outputs frozen for 10 cycles.
REQ-028 Priority and wrap: haltFlag and branchTaken on the same edge -> halted=1 and pc not redirected; separately, pc at 0xFF increments to 0x00 with instr_valid=1.
REQ-029 Reset mid-run: reset while pc=0x40 in RUN -> next cycle state IDLE, pc=0; after a new start, a branch to slot 3 faults (table cleared).
